// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALT,
    FAULT
  } seq_state_e;

  localparam int unsigned INSTR_BYTES  = 4;
  localparam int unsigned JUMP_FIELD_W = 26;

  // Next program counter after an executed instruction.
  // A jump keeps the top nibble of pc+4 and replaces the rest with the word
  // index; a branch adds a word offset to pc+4; otherwise fall through.
  function automatic logic [31:0] nextPc(
    input logic [31:0]             pc,
    input logic                    branchTaken,
    input logic [31:0]             branchOffset,
    input logic                    jumpTaken,
    input logic [JUMP_FIELD_W-1:0] jumpTarget
  );
    logic [31:0] pc4;
    logic [31:0] result;
    pc4 = pc + 32'(INSTR_BYTES);
    if (jumpTaken) begin
      result = {pc4[31:28], jumpTarget, 2'b00};
    end else if (branchTaken) begin
      result = pc4 + (branchOffset << 2);
    end else begin
      result = pc4;
    end
    return result;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous reset to the reset vector, load enable.
module pc_reg #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [31:0] d_i,
  output logic [31:0] q_o
);

  logic [31:0] pc_q;

  // Hold the pc unless a new value is loaded; reset wins over load.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pc_q <= RESET_VECTOR;
    end else if (load_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: drives instruction fetches, computes the next pc,
// counts retired instructions and traps on a fetch that never completes.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic                    start,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic                    imem_ack,
  input  logic [31:0]             imem_data,
  output logic [31:0]             instr,
  output logic                    instr_valid,
  input  logic                    ex_done,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_offset,
  input  logic                    jump,
  input  logic [JUMP_FIELD_W-1:0] jump_target,
  input  logic                    halt_req,
  output logic [31:0]             pc,
  output logic [15:0]             retired,
  output logic                    busy,
  output logic                    halted,
  output logic                    fault
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  seq_state_e        state_q;
  logic [WAIT_W-1:0] waitCnt_q;
  logic [31:0]       instr_q;
  logic              instrValid_q;
  logic              imemReq_q;
  logic              busy_q;
  logic              halted_q;
  logic              fault_q;
  logic [15:0]       retired_q;
  logic [15:0]       retired_d;
  logic              pcLoad;
  logic [31:0]       pc_d;
  logic [31:0]       pcCur;

  pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clock_i(clock),
    .reset_i(Reset),
    .load_i (pcLoad),
    .d_i    (pc_d),
    .q_o    (pcCur)
  );

  // An instruction retires when the datapath reports completion in EXEC;
  // that is the only moment the pc and the retired count move.
  always_comb begin
    pcLoad    = (state_q == EXEC) && ex_done;
    pc_d      = nextPc(pcCur, branch_taken, branch_offset, jump, jump_target);
    retired_d = retired_q;
    if (pcLoad) begin
      retired_d = retired_q + 16'd1;
    end
  end

  // Sequencer FSM with registered status outputs; a fetch acknowledged on
  // the last allowed cycle still completes instead of faulting.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      instr_q      <= '0;
      instrValid_q <= 1'b0;
      imemReq_q    <= 1'b0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      retired_q    <= '0;
    end else begin
      instrValid_q <= 1'b0;
      retired_q    <= retired_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            waitCnt_q <= '0;
            imemReq_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            state_q      <= EXEC;
            instr_q      <= imem_data;
            instrValid_q <= 1'b1;
            waitCnt_q    <= '0;
            imemReq_q    <= 1'b0;
          end else if (waitCnt_q == LAST_WAIT) begin
            state_q   <= FAULT;
            waitCnt_q <= '0;
            imemReq_q <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            waitCnt_q <= waitCnt_q + WAIT_W'(1);
          end
        end
        EXEC: begin
          if (ex_done) begin
            if (halt_req) begin
              state_q  <= HALT;
              busy_q   <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              state_q   <= FETCH;
              imemReq_q <= 1'b1;
            end
          end
        end
        HALT, FAULT: begin
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = imemReq_q;
  assign imem_addr   = pcCur;
  assign pc          = pcCur;
  assign instr       = instr_q;
  assign instr_valid = instrValid_q;
  assign retired     = retired_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;

  logic        clock;
  logic        Reset;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ex_done;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        halt_req;
  logic [31:0] pc;
  logic [15:0] retired;
  logic        busy;
  logic        halted;
  logic        fault;

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clock        (clock),
    .Reset        (Reset),
    .start        (start),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .ex_done      (ex_done),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt_req     (halt_req),
    .pc           (pc),
    .retired      (retired),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault)
  );

  // Free-running 10-time-unit clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    checkOutput({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
    checkOutput({tag, "_fault"}, 32'(fault), 32'd0);
    checkOutput({tag, "_pc"}, pc, 32'h0000_0000);
    checkOutput({tag, "_imem_addr"}, imem_addr, 32'h0000_0000);
    checkOutput({tag, "_instr"}, instr, 32'h0000_0000);
    checkOutput({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  // One whole instruction starting in FETCH: optional stall cycles, the
  // acknowledge, then completion in the first EXEC cycle.
  task automatic applyStimulus(input logic [31:0] data, input int stalls, input logic br,
                               input logic [31:0] off, input logic jmp, input logic [25:0] tgt,
                               input logic halt);
    repeat (stalls) tick();
    imem_ack  = 1'b1;
    imem_data = data;
    tick();
    imem_ack      = 1'b0;
    ex_done       = 1'b1;
    branch_taken  = br;
    branch_offset = off;
    jump          = jmp;
    jump_target   = tgt;
    halt_req      = halt;
    tick();
    ex_done       = 1'b0;
    branch_taken  = 1'b0;
    branch_offset = 32'h0;
    jump          = 1'b0;
    jump_target   = 26'h0;
    halt_req      = 1'b0;
  endtask

  // Directed scenario: reset, basic fetch/execute, branches, jump, wraps,
  // timeout fault, mid-fetch reset and halt.
  initial begin
    Reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    ex_done = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    jump = 1'b0; jump_target = 26'h0; halt_req = 1'b0;
    tick();
    tick();
    checkIdle("reset");
    Reset = 1'b0;

    imem_ack = 1'b1; ex_done = 1'b1; jump = 1'b1; jump_target = 26'h3FF_FFFF;
    tick();
    imem_ack = 1'b0; ex_done = 1'b0; jump = 1'b0; jump_target = 26'h0;
    checkIdle("idle_ignore");

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("start_imem_req", 32'(imem_req), 32'd1);
    checkOutput("start_busy", 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput("stall_imem_req", 32'(imem_req), 32'd1);
    checkOutput("stall_instr_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b1; imem_data = 32'h2001_0005;
    tick();
    imem_ack = 1'b0; imem_data = 32'h0;
    checkOutput("fetch_instr", instr, 32'h2001_0005);
    checkOutput("fetch_instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("fetch_imem_req", 32'(imem_req), 32'd0);
    tick();
    checkOutput("exec_valid_pulse_end", 32'(instr_valid), 32'd0);
    checkOutput("exec_pc_hold", pc, 32'h0000_0000);
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    checkOutput("seq_pc", pc, 32'h0000_0004);
    checkOutput("seq_imem_addr", imem_addr, 32'h0000_0004);
    checkOutput("seq_retired", 32'(retired), 32'd1);
    checkOutput("seq_imem_req", 32'(imem_req), 32'd1);
    checkOutput("seq_instr_hold", instr, 32'h2001_0005);

    applyStimulus(32'h0000_0001, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    applyStimulus(32'h0000_0002, 1, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    applyStimulus(32'h0000_0003, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    checkOutput("seq3_pc", pc, 32'h0000_0010);
    checkOutput("seq3_retired", 32'(retired), 32'd4);

    applyStimulus(32'h1000_FFFE, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0, 1'b0);
    checkOutput("branch_back_pc", pc, 32'h0000_000C);

    applyStimulus(32'h1000_0001, 0, 1'b1, 32'h0FFF_FFFC, 1'b0, 26'h0, 1'b0);
    checkOutput("branch_far_pc", pc, 32'h4000_0000);

    applyStimulus(32'h0800_0040, 0, 1'b1, 32'h0000_0010, 1'b1, 26'h000_0040, 1'b0);
    checkOutput("jump_wins_pc", pc, 32'h4000_0100);
    checkOutput("jump_retired", 32'(retired), 32'd7);

    applyStimulus(32'h1000_0002, 0, 1'b1, 32'h2FFF_FFBE, 1'b0, 26'h0, 1'b0);
    checkOutput("branch_top_pc", pc, 32'hFFFF_FFFC);

    applyStimulus(32'h0000_0004, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    checkOutput("pc_wrap", pc, 32'h0000_0000);
    checkOutput("pc_wrap_imem_addr", imem_addr, 32'h0000_0000);
    checkOutput("pc_wrap_retired", 32'(retired), 32'd9);

    ex_done = 1'b1; jump = 1'b1; jump_target = 26'h3FF_FFFF; halt_req = 1'b1; start = 1'b1;
    repeat (14) tick();
    checkOutput("late_ack_no_fault", 32'(fault), 32'd0);
    checkOutput("late_ack_imem_req", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_data = 32'hCAFE_F00D;
    tick();
    imem_ack = 1'b0; ex_done = 1'b0; jump = 1'b0; jump_target = 26'h0; halt_req = 1'b0; start = 1'b0;
    checkOutput("late_ack_wins_fault", 32'(fault), 32'd0);
    checkOutput("late_ack_instr_valid", 32'(instr_valid), 32'd1);
    checkOutput("late_ack_instr", instr, 32'hCAFE_F00D);
    checkOutput("fetch_ignores_exdone_pc", pc, 32'h0000_0000);
    checkOutput("fetch_ignores_exdone_retired", 32'(retired), 32'd9);

    // Preload the retired counter near its wrap point instead of retiring
    // 65535 instructions.
    force dut.retired_q = 16'hFFFF;
    tick();
    release dut.retired_q;
    tick();
    checkOutput("retired_hold", 32'(retired), 32'h0000_FFFF);
    ex_done = 1'b1;
    tick();
    ex_done = 1'b0;
    checkOutput("retired_wrap", 32'(retired), 32'd0);
    checkOutput("retired_wrap_pc", pc, 32'h0000_0004);

    repeat (14) tick();
    checkOutput("timeout_pre_fault", 32'(fault), 32'd0);
    checkOutput("timeout_pre_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("timeout_fault", 32'(fault), 32'd1);
    checkOutput("timeout_imem_req", 32'(imem_req), 32'd0);
    checkOutput("timeout_busy", 32'(busy), 32'd0);
    start = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; imem_data = 32'h1234_5678;
    repeat (3) tick();
    start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; imem_data = 32'h0;
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_pc_hold", pc, 32'h0000_0004);
    checkOutput("fault_instr_hold", instr, 32'hCAFE_F00D);
    checkOutput("fault_retired_hold", 32'(retired), 32'd0);
    checkOutput("fault_imem_req", 32'(imem_req), 32'd0);

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checkIdle("fault_reset");

    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0);
    checkOutput("pre_midreset_pc", pc, 32'h0000_0004);
    tick();
    Reset = 1'b1; imem_ack = 1'b1; imem_data = 32'h5555_AAAA;
    tick();
    Reset = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    checkIdle("mid_fetch_reset");

    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(32'h1111_1111, 2, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1);
    checkOutput("halt_halted", 32'(halted), 32'd1);
    checkOutput("halt_busy", 32'(busy), 32'd0);
    checkOutput("halt_pc", pc, 32'h0000_0004);
    checkOutput("halt_retired", 32'(retired), 32'd1);
    start = 1'b1; imem_ack = 1'b1; ex_done = 1'b1; branch_taken = 1'b1; branch_offset = 32'h10;
    repeat (3) tick();
    start = 1'b0; imem_ack = 1'b0; ex_done = 1'b0; branch_taken = 1'b0; branch_offset = 32'h0;
    checkOutput("halt_sticky", 32'(halted), 32'd1);
    checkOutput("halt_imem_req", 32'(imem_req), 32'd0);
    checkOutput("halt_pc_hold", pc, 32'h0000_0004);
    checkOutput("halt_retired_hold", 32'(retired), 32'd1);
    checkOutput("halt_instr_hold", instr, 32'h1111_1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, sets the first fetch address after start.
REQ-002 Parameter TIMEOUT, default 15, is the maximum FETCH cycles allowed without imem_ack before a fault.
REQ-003 clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begins sequencing from RESET_VECTOR; sampled in IDLE only.
REQ-006 imem_req  out  1  instruction-memory read request.
REQ-007 imem_addr  out  32  fetch address; always equals pc.
REQ-008 imem_ack  in  1  memory response valid; sampled in FETCH only.
REQ-009 imem_data  in  32  instruction word; valid when imem_ack=1.
REQ-010 instr  out  32  last fetched instruction, held until the next fetch completes.
REQ-011 instr_valid  out  1  one-cycle pulse marking a new instr.
REQ-012 ex_done  in  1  datapath finished executing instr; sampled in EXEC only.
REQ-013 branch_taken  in  1  take branch; sampled with ex_done.
REQ-014 branch_offset  in  32  sign-extended word offset.
REQ-015 jump  in  1  take jump; sampled with ex_done.
REQ-016 jump_target  in  26  jump word index.
REQ-017 halt_req  in  1  stop after the current instruction; sampled with ex_done.
REQ-018 pc  out  32  current program counter.
REQ-019 retired  out  16  retired-instruction count.
REQ-020 busy  out  1  high in FETCH or EXEC.
REQ-021 halted  out  1  high in HALT.
REQ-022 fault  out  1  high in FAULT.

Function
REQ-023 The FSM SHALL have states IDLE, FETCH, EXEC, HALT and FAULT.
REQ-024 IDLE: pc=RESET_VECTOR, imem_req=0; start=1 -> FETCH on the next edge.
REQ-025 FETCH: imem_req=1 and the wait counter increments each cycle.
- On imem_ack=1: instr<=imem_data, wait counter cleared, -> EXEC.
REQ-026 If the wait counter reaches TIMEOUT with imem_ack=0 -> FAULT.
- imem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win (-> EXEC).
REQ-027 instr_valid SHALL be 1 exactly in the first EXEC cycle after each fetch, and 0 otherwise.
REQ-028 EXEC: imem_req=0; on ex_done=1, pc updates on that edge with priority jump > branch_taken > sequential:
- jump: pc <= {pc4[31:28], jump_target, 2'b00}
- branch: pc <= pc4 + (branch_offset<<2)
- sequential: pc <= pc4
- where pc4 = pc+4.
REQ-029 All pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
REQ-030 On ex_done in EXEC, retired SHALL increment by 1, wrapping 16'hFFFF -> 0.
- Next state is HALT if halt_req=1, else FETCH.
REQ-031 HALT and FAULT SHALL hold pc, instr and retired, and leave only on Reset.
- start is ignored in both states.
REQ-032 Inputs outside their sampling state (imem_ack, ex_done, branch/jump/halt) SHALL have no effect.
REQ-033 Latencies: start -> imem_req is 1 cycle; imem_ack -> instr_valid is 1 cycle; ex_done -> next imem_req is 1 cycle.

Reset
REQ-034 Reset=1 at a clock edge SHALL force, taking priority over all other inputs in any state including mid-FETCH:
- state=IDLE, pc=RESET_VECTOR, instr=0, retired=0, wait counter=0
- imem_req=0, instr_valid=0, busy=0, halted=0, fault=0.

Structure
REQ-035 A shared package pc_seq_pkg SHALL hold:
- the state enum
- the constants INSTR_BYTES=4 and JUMP_FIELD_W=26.
REQ-036 The pc register SHALL be a sub-module pc_reg (32-bit, synchronous reset to RESET_VECTOR, load enable); the FSM and next-pc logic stay in pc_sequencer.

Verification
REQ-037 Reset, start, imem_ack after 2 cycles with data 32'h2001_0005, ex_done with no branch or jump:
- instr=32'h2001_0005 with a single instr_valid pulse
- pc 0 -> 4, retired=1.
REQ-038 In EXEC at pc=32'h0000_0010, ex_done with branch_taken=1 and branch_offset=32'hFFFF_FFFE -> pc=32'h0000_000C.
REQ-039 At pc=32'h4000_0000, ex_done with jump=1, jump_target=26'h000_0040 and branch_taken=1 -> pc=32'h4000_0100 (jump wins).
REQ-040 Hold imem_ack=0 for TIMEOUT cycles in FETCH -> fault=1, imem_req=0, and FAULT persists until Reset.
REQ-041 Wrap-arounds:
- pc=32'hFFFF_FFFC, sequential ex_done -> pc=0.
- retired=16'hFFFF, one more ex_done -> retired=0.
REQ-042 Reset asserted mid-FETCH and halt_req with ex_done:
- Reset mid-FETCH -> next cycle IDLE with all outputs at reset values.
- halt_req with ex_done -> halted=1, pc updated once, later start ignored.
